// File: rtl/mdio_master.sv
// Clause-22 MDIO/SMI master: shifts one read or write frame per request and
// derives MDC from clk, CLK_DIV clk cycles per MDC half-period.
module mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  // Handshake: a request is taken on any clk edge where start=1 and busy=0;
  // done pulses for exactly one cycle when the frame ends, and busy is low in
  // that same cycle so a new start may be issued there.

  typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, FIN} state_t;

  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DIV_HIGH = 9'(CLK_DIV);
  localparam logic [8:0] DIV_RISE = 9'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      state, state_nxt;
  logic [8:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic        rw_q;
  logic [15:0] rd_shift;
  logic        ta_err;
  logic        accept;
  logic        bit_end;
  logic        pre_last;
  logic        frame_last;
  logic        in_frame;

  assign in_frame   = (state == PREAMBLE) || (state == FRAME);
  assign accept     = start && !in_frame;
  assign bit_end    = (div_cnt == DIV_LAST);
  assign pre_last   = (bit_cnt == PRE_LAST);
  assign frame_last = (bit_cnt == 6'd31);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = (PREAMBLE_LEN == 0) ? FRAME : PREAMBLE;
      PREAMBLE: if (bit_end && pre_last) state_nxt = FRAME;
      FRAME:    if (bit_end && frame_last) state_nxt = FIN;
      FIN: begin
        if (start) state_nxt = (PREAMBLE_LEN == 0) ? FRAME : PREAMBLE;
        else       state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Datapath: bit timing, shift register, read sampling and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw_q     <= 1'b0;
      rd_shift <= '0;
      ta_err   <= 1'b0;
      rd_data  <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      shreg    <= {2'b01, (rw ? 2'b10 : 2'b01), phy_addr, reg_addr, 2'b10, wr_data};
      rw_q     <= rw;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      rd_shift <= '0;
      ta_err   <= 1'b0;
    end else if (in_frame) begin
      div_cnt <= bit_end ? 9'd0 : div_cnt + 9'd1;
      if (bit_end) begin
        bit_cnt <= (state == PREAMBLE && pre_last) ? 6'd0 : bit_cnt + 6'd1;
        if (state == FRAME) shreg <= {shreg[30:0], 1'b0};
      end
      // mdio_i is taken on the edge where mdc goes high
      if (state == FRAME && rw_q && div_cnt == DIV_RISE) begin
        if (bit_cnt == 6'd15) ta_err <= mdio_i;
        if (bit_cnt >= 6'd16) rd_shift <= {rd_shift[14:0], mdio_i};
      end
      if (state == FRAME && bit_end && frame_last) begin
        if (rw_q) begin
          rd_data <= rd_shift;
          err     <= ta_err;
        end else begin
          err <= 1'b0;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    busy    = in_frame;
    done    = (state == FIN);
    mdc     = in_frame && (div_cnt >= DIV_HIGH);
    mdio_o  = 1'b1;
    mdio_oe = 1'b0;
    case (state)
      PREAMBLE: begin
        mdio_o  = 1'b1;
        mdio_oe = 1'b1;
      end
      FRAME: begin
        mdio_o  = shreg[31];
        mdio_oe = !rw_q || (bit_cnt < 6'd14);
      end
      default: begin
        mdio_o  = 1'b1;
        mdio_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: one instance with a 32-bit preamble and one
// with no preamble for back-to-back frames, both at CLK_DIV=2.
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CLK_DIV=2, PREAMBLE_LEN=32
  logic        a_start = 1'b0, a_rw = 1'b0;
  logic [4:0]  a_phy = '0, a_reg = '0;
  logic [15:0] a_wr_data = '0;
  logic [15:0] a_rd_data;
  logic        a_busy, a_done, a_err, a_mdc, a_mdio_o, a_mdio_oe;
  logic        a_mdio_i = 1'b1;

  // Instance B: CLK_DIV=2, PREAMBLE_LEN=0
  logic        b_start = 1'b0, b_rw = 1'b0;
  logic [4:0]  b_phy = '0, b_reg = '0;
  logic [15:0] b_wr_data = '0;
  logic [15:0] b_rd_data;
  logic        b_busy, b_done, b_err, b_mdc, b_mdio_o, b_mdio_oe;
  logic        b_mdio_i = 1'b1;

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .rw(a_rw), .phy_addr(a_phy),
    .reg_addr(a_reg), .wr_data(a_wr_data), .rd_data(a_rd_data), .busy(a_busy),
    .done(a_done), .err(a_err), .mdc(a_mdc), .mdio_o(a_mdio_o),
    .mdio_oe(a_mdio_oe), .mdio_i(a_mdio_i)
  );

  mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .rw(b_rw), .phy_addr(b_phy),
    .reg_addr(b_reg), .wr_data(b_wr_data), .rd_data(b_rd_data), .busy(b_busy),
    .done(b_done), .err(b_err), .mdc(b_mdc), .mdio_o(b_mdio_o),
    .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // PHY model on instance A: after each mdc rise it drives the value for the
  // next frame bit (TA second bit 0, then phy_data MSB first).
  logic        phy_en = 1'b0;
  logic [15:0] phy_data = '0;
  int          rise_cnt = 0;

  always @(posedge a_mdc) begin
    int nb;
    nb = rise_cnt - 32 + 1;
    rise_cnt++;
    #1;
    if (!phy_en)                a_mdio_i = 1'b1;
    else if (nb == 15)          a_mdio_i = 1'b0;
    else if (nb >= 16 && nb <= 31) a_mdio_i = phy_data[31 - nb];
    else                        a_mdio_i = 1'b1;
  end

  // Run one frame on instance A, checking every bit period, mdc phase and done.
  // extra_cyc: cycle at which a second (to be ignored) start is pulsed, -1 none.
  task automatic a_frame(input logic rw_v, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] data, input logic [31:0] exp_bits,
                         input int extra_cyc, input logic [15:0] exp_rd,
                         input logic exp_err);
    int bi, ph, fb;
    logic exp_oe;
    @(negedge clk);
    a_start = 1'b1; a_rw = rw_v; a_phy = phy; a_reg = rg; a_wr_data = data;
    rise_cnt = 0;
    a_mdio_i = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 258; cyc++) begin
      #1;
      if (cyc == extra_cyc) begin
        a_start = 1'b1; a_rw = ~rw_v; a_phy = ~phy; a_reg = ~rg; a_wr_data = ~data;
      end else begin
        a_start = 1'b0; a_rw = rw_v; a_phy = phy; a_reg = rg; a_wr_data = data;
      end
      @(negedge clk);
      if (cyc <= 256) begin
        bi = (cyc - 1) / 4;
        ph = (cyc - 1) % 4;
        fb = bi - 32;
        if (ph == 0) begin
          exp_oe = (bi < 32) ? 1'b1 : (!rw_v || fb < 14);
          chk("busy_in_frame", a_busy, 1);
          chk("mdc_low", a_mdc, 0);
          chk("mdio_oe_bit", a_mdio_oe, exp_oe);
          if (exp_oe)
            chk("mdio_o_bit", a_mdio_o, (bi < 32) ? 1'b1 : exp_bits[31 - fb]);
        end
        if (ph == 2) chk("mdc_high", a_mdc, 1);
        if (cyc == 256) chk("done_early", a_done, 0);
      end else if (cyc == 257) begin
        chk("done_pulse", a_done, 1);
        chk("busy_at_done", a_busy, 0);
        chk("mdc_at_done", a_mdc, 0);
        chk("oe_at_done", a_mdio_oe, 0);
        chk("o_at_done", a_mdio_o, 1);
        chk("rd_data_at_done", a_rd_data, exp_rd);
        chk("err_at_done", a_err, exp_err);
      end else begin
        chk("done_one_cycle", a_done, 0);
        chk("busy_after", a_busy, 0);
      end
      @(posedge clk);
    end
  endtask

  // Bit and done checks for one frame on instance B; optionally chains the
  // next start into the done cycle.
  task automatic b_frame(input logic [31:0] exp_bits, input logic chain,
                         input logic [4:0] nphy, input logic [4:0] nrg,
                         input logic [15:0] ndata);
    int bi, ph;
    for (int cyc = 1; cyc <= 129; cyc++) begin
      #1;
      b_start = 1'b0;
      @(negedge clk);
      if (cyc <= 128) begin
        bi = (cyc - 1) / 4;
        ph = (cyc - 1) % 4;
        if (ph == 0) begin
          chk("b_busy", b_busy, 1);
          chk("b_oe", b_mdio_oe, 1);
          chk("b_mdio_o", b_mdio_o, exp_bits[31 - bi]);
        end
        if (ph == 2) chk("b_mdc_high", b_mdc, 1);
        if (cyc == 128) chk("b_done_early", b_done, 0);
      end else begin
        chk("b_done", b_done, 1);
        chk("b_busy_at_done", b_busy, 0);
        chk("b_err_write", b_err, 0);
        if (chain) begin
          b_start = 1'b1; b_rw = 1'b0; b_phy = nphy; b_reg = nrg; b_wr_data = ndata;
        end
      end
      @(posedge clk);
    end
    #1;
    b_start = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_mdc", a_mdc, 0);
    chk("rst_mdio_o", a_mdio_o, 1);
    chk("rst_mdio_oe", a_mdio_oe, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_b_busy", b_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Write phy 1 reg 0 = 0x3100
    a_frame(1'b0, 5'd1, 5'd0, 16'h3100, 32'h5082_3100, -1, 16'h0000, 1'b0);

    // Read phy 1 reg 1 with PHY answering 0x7809
    phy_en = 1'b1; phy_data = 16'h7809;
    a_frame(1'b1, 5'd1, 5'd1, 16'h0000, 32'h6086_0000, -1, 16'h7809, 1'b0);

    // Read with no PHY: mdio_i stays high
    phy_en = 1'b0;
    a_frame(1'b1, 5'd1, 5'd1, 16'h0000, 32'h6086_0000, -1, 16'hFFFF, 1'b1);

    // Write with a second start at cycle 50: ignored, rd_data kept, err cleared
    a_frame(1'b0, 5'd1, 5'd0, 16'h3100, 32'h5082_3100, 50, 16'hFFFF, 1'b0);

    // Reset at cycle 100 of a read
    phy_en = 1'b1; phy_data = 16'h1234;
    @(negedge clk);
    a_start = 1'b1; a_rw = 1'b1; a_phy = 5'd1; a_reg = 5'd1;
    rise_cnt = 0;
    @(posedge clk);
    #1 a_start = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mdc", a_mdc, 0);
    chk("abort_oe", a_mdio_oe, 0);
    chk("abort_o", a_mdio_o, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_rd_data", a_rd_data, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", a_done, 0);
    rst_n = 1'b1;
    phy_en = 1'b0;
    repeat (2) @(posedge clk);
    a_frame(1'b0, 5'd1, 5'd0, 16'h3100, 32'h5082_3100, -1, 16'h0000, 1'b0);

    // Back-to-back on instance B, start chained into the done cycle
    @(negedge clk);
    b_start = 1'b1; b_rw = 1'b0; b_phy = 5'd2; b_reg = 5'd4; b_wr_data = 16'h1234;
    @(posedge clk);
    b_frame(32'h5112_1234, 1'b1, 5'd2, 5'd4, 16'hBEEF);
    b_frame(32'h5112_BEEF, 1'b0, 5'd0, 5'd0, 16'h0000);
    @(negedge clk);
    chk("b_idle_after", b_busy, 0);
    chk("b_mdc_idle", b_mdc, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
